// File: rtl/instr_dcd_pkg.sv
// Shared types and constants for the SPI instruction decoder.
// Holds the header field layout and the register-map legality rules.
package dcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DATA = 2'd2
  } dcd_state_e;

  localparam int HDR_RW_BIT   = 7;
  localparam int HDR_ADDR_MSB = 5;
  localparam int REG_ADDR_W   = HDR_ADDR_MSB + 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t LAST_REG_ADDR = 6'h0D;
  localparam reg_addr_t RO_ADDR_A     = 6'h08;
  localparam reg_addr_t RO_ADDR_B     = 6'h09;

  // Reads may target any mapped register; writes additionally skip the read-only pair.
  function automatic logic access_legal(input reg_addr_t a, input logic is_wr);
    if (a > LAST_REG_ADDR) return 1'b0;
    if (is_wr && (a == RO_ADDR_A || a == RO_ADDR_B)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/instr_dcd_if.sv
// Bus bundle between SPI bridge, decoder and register file.
// The master modport is the decoder's view; slave is the surrounding logic.
interface instr_dcd_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              byte_sync;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;
  logic              err;

  modport master (
    input  byte_sync, data_in, data_read,
    output data_out, read, write, addr, data_write, err
  );

  modport slave (
    output byte_sync, data_in, data_read,
    input  data_out, read, write, addr, data_write, err
  );
endinterface

// File: rtl/instr_dcd.sv
// Two-byte frame decoder (header + payload) driving register file strobes.
// Optional DCD_ADDR_CHECK_EN suppresses illegal accesses and raises sticky err.
module instr_dcd
  import dcd_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  instr_dcd_if.master bus
);

  dcd_state_e        state;
  logic              is_write;
  logic              frame_ok;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_write_q;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_ok;
  logic              unused_rsvd;

  assign hdr_addr    = bus.data_in[HDR_ADDR_MSB:0];
  assign unused_rsvd = bus.data_in[6];

`ifdef DCD_ADDR_CHECK_EN
  assign hdr_ok = access_legal(hdr_addr, bus.data_in[HDR_RW_BIT]);
`else
  assign hdr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      frame_ok     <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_write_q <= '0;
      data_out_q   <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.byte_sync) begin
            addr_q   <= hdr_addr;
            is_write <= bus.data_in[HDR_RW_BIT];
            frame_ok <= hdr_ok;
            if (bus.data_in[HDR_RW_BIT]) begin
              state <= DATA;
            end else begin
              read_q <= hdr_ok;
              state  <= RD;
            end
          end
        end
        // A payload byte landing in the strobe cycle still closes the frame.
        RD: begin
          data_out_q <= frame_ok ? bus.data_read : '0;
          state      <= bus.byte_sync ? IDLE : DATA;
        end
        DATA: begin
          if (bus.byte_sync) begin
            if (is_write && frame_ok) begin
              data_write_q <= bus.data_in;
              write_q      <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCD_ADDR_CHECK_EN
  logic err_q;
  logic err_set;

  // err rises in the cycle the suppressed strobe would have appeared.
  always_comb begin
    err_set = 1'b0;
    if (bus.byte_sync) begin
      if (state == IDLE && !bus.data_in[HDR_RW_BIT] && !hdr_ok) err_set = 1'b1;
      if (state == DATA && is_write && !frame_ok) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | err_set;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = data_write_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: doc/instr_dcd.md
# instr_dcd

Byte-level instruction decoder between the SPI byte bridge and the register file. Consumes two-byte frames (header + payload), drives the register file's `read`/`write`/`addr`/`data_write` strobes, and returns register read data on `data_out` for the bridge to shift out. One frame is one register access.

## Interface
Parameters:
- `ADDR_W`, 6: register address width.
- `DATA_W`, 8: byte width.

Ports:
- `clk`  in  1  peripheral clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `byte_sync`  in  1  one-cycle pulse: `data_in` holds a complete received byte.
- `data_in`  in  8  received byte from the SPI bridge.
- `data_out`  out  8  byte the bridge transmits on the next transfer.
- `read`  out  1  register read strobe, one cycle.
- `write`  out  1  register write strobe, one cycle.
- `addr`  out  6  register address, held between frames.
- `data_write`  out  8  write payload, held between frames.
- `data_read`  in  8  combinational read data from the register file.
- `err`  out  1  sticky illegal-access flag (see Configuration).

## Operation
- Header byte fields:
  - bit7 is the direction: 1 = write, 0 = read.
  - bit6 is reserved and ignored.
  - bits5:0 are the address.
- FSM states are IDLE, RD, DATA.
- IDLE:
  - On `byte_sync`, latch `addr <= data_in[5:0]` and the direction bit.
  - Write header: go to DATA.
  - Read header: go to RD.
- RD:
  - Single cycle with `read=1`.
  - Latch `data_out <= data_read` at the end of the cycle.
  - Then go to DATA. The payload byte for a read is a dummy.
- DATA:
  - On `byte_sync`, for a write frame: `data_write <= data_in`, pulse `write` in the next cycle.
  - On `byte_sync`, for a read frame: discard the byte.
  - Return to IDLE.
- A `byte_sync` arriving in RD counts as the payload byte. The read still completes, and the FSM returns directly to IDLE.
- `data_out` holds its value until the next read capture. Writes never change it.
- `addr` and `data_write` change only on header and write-payload capture respectively.
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `read`=0, `write`=0.
  - `addr`=0, `data_write`=0, `data_out`=0.
  - `err`=0.
- Reset asserted mid-frame aborts the frame. No strobe is issued; the next byte is treated as a header.

## Timing
- Header `byte_sync` at cycle n:
  - `addr` is valid at n+1.
  - For a read, `read`=1 at n+1 and `data_out` is valid at n+2.
- Write payload `byte_sync` at cycle m: `write`=1 and `data_write` are valid at m+1, for exactly one cycle.
- Back-to-back frames:
  - A header `byte_sync` in the same cycle a `write` strobe is high is accepted normally.
  - Minimum spacing between any two `byte_sync` pulses is 1 cycle.
- `read` and `write` are never high together.

## Configuration
- Macro `DCD_ADDR_CHECK_EN`.
- Defined:
  - Addresses above 6'h0D are illegal for any access.
  - A write to 6'h07, 6'h08 or 6'h09 is legal only for 6'h07; writes to 6'h08 and 6'h09 (read-only) are illegal.
  - An illegal access suppresses its `read`/`write` strobe. An illegal read leaves `data_out`=8'h00.
  - The frame still consumes both bytes.
  - `err` sets on the strobe cycle that would have occurred and clears only on reset.
- Not defined: every address is passed through and `err` is tied 0.

## Structure
- Shared package `dcd_pkg` holds:
  - The FSM state enum.
  - Header field positions (`HDR_RW_BIT`=7, `HDR_ADDR_MSB`=5).
  - `LAST_REG_ADDR`=6'h0D.
  - Read-only address constants 6'h08 and 6'h09.
- Single module; no sub-module is warranted.

## Test plan
- Write frame 8'h80, 8'h5A → `write`=1 one cycle after the second `byte_sync`, `addr`=6'h00, `data_write`=8'h5A.
- Read frame 8'h0A, 8'hFF with `data_read`=8'h3C → `read` pulses at n+1; `data_out`=8'h3C from n+2 and held through a following write frame.
- Read header immediately followed by `byte_sync` in the RD cycle → read completes, FSM returns to IDLE, next byte 8'h81 is taken as a header (`addr`=6'h01).
- Reset asserted after write header 8'h82 → no `write`; after release, frame 8'h83, 8'h11 writes 8'h11 to 6'h03.
- With `DCD_ADDR_CHECK_EN`:
  - Write frame 8'h88, 8'h01 → no `write`, `err`=1 sticky.
  - Read of 6'h20 → no `read`, `data_out`=8'h00.
- Without `DCD_ADDR_CHECK_EN`: write to 6'h3F passes through with `write`=1 and `err`=0.
